// File: rtl/pipe_control.sv
// pipe_control: ID-stage opcode decode feeding registered ID/EX, EX/MEM, MEM/WB control stages
// with stall/flush/bubble generation. Optional macro DATA_FWD_EN adds EX forwarding selects fwd_a/fwd_b.
module pipe_control #(
  parameter int OP_W     = 6,
  parameter int REG_AW   = 5,
  parameter int MUL_LAT  = 3,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush,
  output logic [6:0]        ex_ctrl,
  output logic              ex_jump,
  output logic [1:0]        mem_ctrl,
  output logic [1:0]        wb_ctrl,
  output logic [REG_AW-1:0] ex_wdst,
  output logic [REG_AW-1:0] mem_wdst,
  output logic [REG_AW-1:0] wb_wdst,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid
`ifdef DATA_FWD_EN
  ,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`endif
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'h01);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6'h03);
  localparam logic [OP_W-1:0] OP_COM  = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(6'h05);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h06);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h07);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h09);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h0A);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'h0B);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(6'h0C);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

  typedef struct packed {
    logic       alusrc;
    logic [3:0] aluop;
    logic       branch;
    logic       jr;
    logic       jump;
    logic       mem_write;
    logic       mem_read;
    logic       wen;
    logic       mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic mem_write;
    logic mem_read;
    logic wen;
    logic mem_to_reg;
  } mctl_t;

  ctrl_t             dec, ex_r;
  mctl_t             mem_r;
  logic [1:0]        wb_r;
  logic              regdst, jal, rt_src, is_mul;
  logic [REG_AW-1:0] id_wdst;
  logic [CNT_W-1:0]  mul_cnt;
  logic              mul_busy, raw_stall, ex_hit, ex_hold, ex_load;

  always_comb begin
    dec       = '0;
    dec.aluop = id_opcode[3:0];
    regdst    = 1'b0;
    jal       = 1'b0;
    rt_src    = 1'b0;
    case (id_opcode)
      OP_ADD, OP_SUB: begin
        dec.wen = 1'b1; dec.mem_to_reg = 1'b1; regdst = 1'b1; rt_src = 1'b1;
      end
      OP_AND, OP_XOR, OP_MUL: begin
        dec.wen = 1'b1; dec.mem_to_reg = 1'b1; rt_src = 1'b1;
      end
      OP_COM:  begin dec.wen = 1'b1; dec.mem_to_reg = 1'b1; end
      OP_ADDI: begin dec.wen = 1'b1; dec.alusrc = 1'b1; dec.mem_to_reg = 1'b1; end
      OP_LW:   begin dec.wen = 1'b1; dec.alusrc = 1'b1; dec.mem_read = 1'b1; end
      OP_SW:   begin dec.alusrc = 1'b1; dec.mem_write = 1'b1; rt_src = 1'b1; end
      OP_BEQ:  begin dec.branch = 1'b1; rt_src = 1'b1; end
      OP_J:    dec.jump = 1'b1;
      OP_JAL:  begin dec.jump = 1'b1; jal = 1'b1; dec.wen = 1'b1; end
      OP_JR:   dec.jr = 1'b1;
      default: dec = '0;
    endcase
  end

  assign is_mul  = (id_opcode == OP_MUL);
  assign id_wdst = jal ? REG_AW'(LINK_REG) : (regdst ? id_rd : id_rt);

  // Register 0 is never a real producer, so it can't create a hazard.
  assign ex_hit = (ex_wdst != '0) && ((ex_wdst == id_rs) || (rt_src && (ex_wdst == id_rt)));

`ifdef DATA_FWD_EN
  assign raw_stall = id_valid && ex_valid && ex_r.mem_read && ex_r.wen && ex_hit;
`else
  logic mem_hit;
  assign mem_hit   = (mem_wdst != '0) && ((mem_wdst == id_rs) || (rt_src && (mem_wdst == id_rt)));
  assign raw_stall = id_valid && ((ex_valid && ex_r.wen && ex_hit) ||
                                  (mem_valid && mem_r.wen && mem_hit));
`endif

  assign mul_busy = (mul_cnt != '0);
  assign flush    = ex_valid && ((ex_r.branch && br_taken) || ex_r.jump || ex_r.jr);
  assign stall    = !flush && (mul_busy || raw_stall);
  assign ex_hold  = mul_busy && !flush;
  assign ex_load  = !flush && !mul_busy && !raw_stall && id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r      <= '0;
      ex_valid  <= 1'b0;
      ex_wdst   <= '0;
      mem_r     <= '0;
      mem_valid <= 1'b0;
      mem_wdst  <= '0;
      wb_r      <= '0;
      wb_valid  <= 1'b0;
      wb_wdst   <= '0;
      mul_cnt   <= '0;
    end else begin
      wb_r     <= {mem_r.wen, mem_r.mem_to_reg};
      wb_valid <= mem_valid;
      wb_wdst  <= mem_wdst;
      if (ex_hold) begin
        // MUL still occupies EX: bubbles drain into MEM behind it.
        mem_r     <= '0;
        mem_valid <= 1'b0;
        mem_wdst  <= '0;
        mul_cnt   <= mul_cnt - CNT_W'(1);
      end else begin
        mem_r     <= {ex_r.mem_write, ex_r.mem_read, ex_r.wen, ex_r.mem_to_reg};
        mem_valid <= ex_valid;
        mem_wdst  <= ex_wdst;
        if (ex_load) begin
          ex_r     <= dec;
          ex_valid <= 1'b1;
          ex_wdst  <= id_wdst;
          mul_cnt  <= is_mul ? MUL_LOAD : '0;
        end else begin
          ex_r     <= '0;
          ex_valid <= 1'b0;
          ex_wdst  <= '0;
        end
      end
    end
  end

  assign ex_ctrl  = {ex_r.alusrc, ex_r.aluop, ex_r.branch, ex_r.jr};
  assign ex_jump  = ex_r.jump;
  assign mem_ctrl = {mem_r.mem_write, mem_r.mem_read};
  assign wb_ctrl  = wb_r;

`ifdef DATA_FWD_EN
  logic [REG_AW-1:0] ex_rs, ex_rt;
  logic              ex_rt_src, mem_ok, wb_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rt_src <= 1'b0;
    end else if (!ex_hold) begin
      ex_rs     <= ex_load ? id_rs  : '0;
      ex_rt     <= ex_load ? id_rt  : '0;
      ex_rt_src <= ex_load ? rt_src : 1'b0;
    end
  end

  assign mem_ok = mem_valid && mem_r.wen && (mem_wdst != '0);
  assign wb_ok  = wb_valid && wb_r[1] && (wb_wdst != '0);

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_valid) begin
      if (mem_ok && (mem_wdst == ex_rs))     fwd_a = 2'b01;
      else if (wb_ok && (wb_wdst == ex_rs))  fwd_a = 2'b10;
      if (ex_rt_src) begin
        if (mem_ok && (mem_wdst == ex_rt))    fwd_b = 2'b01;
        else if (wb_ok && (wb_wdst == ex_rt)) fwd_b = 2'b10;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: decode table through all three stages plus hazard/flush/reset sequences.
module tb_pipe_control;
  localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_AND = 6'h02, OP_XOR = 6'h03,
                         OP_COM = 6'h04, OP_MUL = 6'h05, OP_ADDI = 6'h06, OP_LW = 6'h07,
                         OP_SW = 6'h08, OP_BEQ = 6'h09, OP_J = 6'h0A, OP_JAL = 6'h0B,
                         OP_JR = 6'h0C, OP_UNK = 6'h3F;

  logic       clk, rst_n, id_valid, br_taken;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       stall, flush, ex_jump, ex_valid, mem_valid, wb_valid;
  logic [6:0] ex_ctrl;
  logic [1:0] mem_ctrl, wb_ctrl;
  logic [4:0] ex_wdst, mem_wdst, wb_wdst;
`ifdef DATA_FWD_EN
  logic [1:0] fwd_a, fwd_b;
`endif

  pipe_control dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .br_taken(br_taken),
    .stall(stall), .flush(flush), .ex_ctrl(ex_ctrl), .ex_jump(ex_jump),
    .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .ex_wdst(ex_wdst), .mem_wdst(mem_wdst),
    .wb_wdst(wb_wdst), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid)
`ifdef DATA_FWD_EN
    , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply new ID inputs just after a rising edge, then return at the falling edge for sampling.
  task automatic cyc(input logic v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic bt);
    @(posedge clk);
    #1;
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; br_taken = bt;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, OP_UNK, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  typedef struct {
    logic [5:0] op;
    logic [6:0] ectl;
    logic       jmp;
    logic       fl;
    logic [1:0] mctl;
    logic [1:0] wctl;
    logic [4:0] wd;
  } vec_t;

  vec_t tbl [0:12];

  initial begin
    tbl[0]  = '{OP_ADD,  7'b0000000, 1'b0, 1'b0, 2'b00, 2'b11, 5'd3};
    tbl[1]  = '{OP_SUB,  7'b0000100, 1'b0, 1'b0, 2'b00, 2'b11, 5'd3};
    tbl[2]  = '{OP_AND,  7'b0001000, 1'b0, 1'b0, 2'b00, 2'b11, 5'd2};
    tbl[3]  = '{OP_XOR,  7'b0001100, 1'b0, 1'b0, 2'b00, 2'b11, 5'd2};
    tbl[4]  = '{OP_COM,  7'b0010000, 1'b0, 1'b0, 2'b00, 2'b11, 5'd2};
    tbl[5]  = '{OP_ADDI, 7'b1011000, 1'b0, 1'b0, 2'b00, 2'b11, 5'd2};
    tbl[6]  = '{OP_LW,   7'b1011100, 1'b0, 1'b0, 2'b01, 2'b10, 5'd2};
    tbl[7]  = '{OP_SW,   7'b1100000, 1'b0, 1'b0, 2'b10, 2'b00, 5'd2};
    tbl[8]  = '{OP_BEQ,  7'b0100110, 1'b0, 1'b0, 2'b00, 2'b00, 5'd2};
    tbl[9]  = '{OP_J,    7'b0101000, 1'b1, 1'b1, 2'b00, 2'b00, 5'd2};
    tbl[10] = '{OP_JAL,  7'b0101100, 1'b1, 1'b1, 2'b00, 2'b10, 5'd31};
    tbl[11] = '{OP_JR,   7'b0110001, 1'b0, 1'b1, 2'b00, 2'b00, 5'd2};
    tbl[12] = '{OP_UNK,  7'b0000000, 1'b0, 1'b0, 2'b00, 2'b00, 5'd2};

    rst_n = 1'b0; id_valid = 1'b0; id_opcode = OP_UNK; id_rs = '0; id_rt = '0; id_rd = '0;
    br_taken = 1'b0;
    #2;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_wb_wdst", wb_wdst, 0);
    #6 rst_n = 1'b1;

    // Decode table: one instruction at a time, followed through EX, MEM and WB.
    for (int i = 0; i < 13; i++) begin
      cyc(1'b1, tbl[i].op, 5'd1, 5'd2, 5'd3, 1'b0);
      chk("tbl_id_stall", stall, 0);
      idle(1);
      chk("tbl_ex_valid", ex_valid, 1);
      chk("tbl_ex_ctrl", ex_ctrl, tbl[i].ectl);
      chk("tbl_ex_jump", ex_jump, tbl[i].jmp);
      chk("tbl_flush", flush, tbl[i].fl);
      chk("tbl_ex_wdst", ex_wdst, tbl[i].wd);
      idle(1);
      chk("tbl_mem_valid", mem_valid, 1);
      chk("tbl_mem_ctrl", mem_ctrl, tbl[i].mctl);
      chk("tbl_mem_wdst", mem_wdst, tbl[i].wd);
      chk("tbl_mem_ex_valid", ex_valid, 0);
      idle(1);
      chk("tbl_wb_valid", wb_valid, 1);
      chk("tbl_wb_ctrl", wb_ctrl, tbl[i].wctl);
      chk("tbl_wb_wdst", wb_wdst, tbl[i].wd);
    end
    idle(1);

    // ADD r3,r1,r2 then ADD r4,r3,r3
    cyc(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    chk("raw_first_stall", stall, 0);
    cyc(1'b1, OP_ADD, 5'd3, 5'd3, 5'd4, 1'b0);
`ifdef DATA_FWD_EN
    chk("raw_fwd_nostall", stall, 0);
    idle(1);
    chk("raw_fwd_ex_wdst", ex_wdst, 4);
    chk("raw_fwd_a", fwd_a, 2'b01);
    chk("raw_fwd_b", fwd_b, 2'b01);
`else
    chk("raw_stall_c1", stall, 1);
    cyc(1'b1, OP_ADD, 5'd3, 5'd3, 5'd4, 1'b0);
    chk("raw_stall_c2", stall, 1);
    chk("raw_bubble_c2", ex_valid, 0);
    chk("raw_mem_wdst", mem_wdst, 3);
    cyc(1'b1, OP_ADD, 5'd3, 5'd3, 5'd4, 1'b0);
    chk("raw_release", stall, 0);
    chk("raw_wb_wdst", wb_wdst, 3);
    idle(1);
    chk("raw_ex_valid", ex_valid, 1);
    chk("raw_ex_wdst", ex_wdst, 4);
`endif
    idle(3);

    // LW r5 then SUB r6,r5,r1
    cyc(1'b1, OP_LW, 5'd0, 5'd5, 5'd0, 1'b0);
    cyc(1'b1, OP_SUB, 5'd5, 5'd1, 5'd6, 1'b0);
    chk("lu_stall", stall, 1);
    chk("lu_ex_wdst", ex_wdst, 5);
    cyc(1'b1, OP_SUB, 5'd5, 5'd1, 5'd6, 1'b0);
    chk("lu_bubble", ex_valid, 0);
`ifdef DATA_FWD_EN
    chk("lu_one_cycle", stall, 0);
    idle(1);
    chk("lu_sub_in_ex", ex_valid, 1);
    chk("lu_sub_wdst", ex_wdst, 6);
    chk("lu_fwd_a_wb", fwd_a, 2'b10);
    chk("lu_fwd_b", fwd_b, 2'b00);
`else
    chk("lu_raw_stall2", stall, 1);
    cyc(1'b1, OP_SUB, 5'd5, 5'd1, 5'd6, 1'b0);
    chk("lu_release", stall, 0);
    chk("lu_bubble2", ex_valid, 0);
    idle(1);
    chk("lu_sub_in_ex", ex_valid, 1);
    chk("lu_sub_wdst", ex_wdst, 6);
`endif
    idle(3);

    // MUL (dest r7) then independent ADD r8
    cyc(1'b1, OP_MUL, 5'd1, 5'd7, 5'd0, 1'b0);
    chk("mul_id_stall", stall, 0);
    cyc(1'b1, OP_ADD, 5'd1, 5'd2, 5'd8, 1'b0);
    chk("mul_stall1", stall, 1);
    chk("mul_ex_ctrl", ex_ctrl, 7'b0010100);
    chk("mul_ex_wdst", ex_wdst, 7);
    cyc(1'b1, OP_ADD, 5'd1, 5'd2, 5'd8, 1'b0);
    chk("mul_stall2", stall, 1);
    chk("mul_mem_bubble1", mem_valid, 0);
    chk("mul_ex_hold", ex_wdst, 7);
    cyc(1'b1, OP_ADD, 5'd1, 5'd2, 5'd8, 1'b0);
    chk("mul_release", stall, 0);
    chk("mul_mem_bubble2", mem_valid, 0);
    chk("mul_ex_hold2", ex_valid, 1);
    idle(1);
    chk("mul_add_in_ex", ex_wdst, 8);
    chk("mul_to_mem_v", mem_valid, 1);
    chk("mul_to_mem_wdst", mem_wdst, 7);
    idle(3);

    // Asynchronous reset mid-MUL with a valid instruction in MEM
    cyc(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    cyc(1'b1, OP_MUL, 5'd1, 5'd7, 5'd0, 1'b0);
    cyc(1'b1, OP_ADD, 5'd1, 5'd2, 5'd8, 1'b0);
    chk("ar_pre_stall", stall, 1);
    chk("ar_pre_mem_valid", mem_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ex_valid", ex_valid, 0);
    chk("ar_mem_valid", mem_valid, 0);
    chk("ar_mem_wdst", mem_wdst, 0);
    chk("ar_ex_ctrl", ex_ctrl, 0);
    chk("ar_stall", stall, 0);
    id_valid = 1'b0;
    #1 rst_n = 1'b1;
    idle(1);
    chk("ar_mul_abandoned", stall, 0);
    chk("ar_ex_idle", ex_valid, 0);
    idle(2);

    // Taken BEQ in EX while a would-be stalled SUB sits in ID
    cyc(1'b1, OP_LW, 5'd0, 5'd5, 5'd0, 1'b0);
    cyc(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    chk("br_no_stall", stall, 0);
    cyc(1'b1, OP_SUB, 5'd5, 5'd1, 5'd6, 1'b1);
    chk("br_flush", flush, 1);
    chk("br_flush_nostall", stall, 0);
    idle(1);
    chk("br_squash", ex_valid, 0);
    chk("br_flush_drop", flush, 0);
    chk("br_in_mem", mem_valid, 1);
    idle(3);

    // JAL: link register written back
    cyc(1'b1, OP_JAL, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    chk("jal_ex_jump", ex_jump, 1);
    chk("jal_flush", flush, 1);
    chk("jal_ex_wdst", ex_wdst, 31);
    idle(1);
    chk("jal_squash", ex_valid, 0);
    chk("jal_mem_wdst", mem_wdst, 31);
    idle(1);
    chk("jal_wb_valid", wb_valid, 1);
    chk("jal_wb_wdst", wb_wdst, 31);
    chk("jal_wb_ctrl", wb_ctrl, 2'b10);
    idle(3);

    // Destination r0 never stalls; invalid ID never stalls
    cyc(1'b1, OP_LW, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b1, OP_SUB, 5'd0, 5'd1, 5'd6, 1'b0);
    chk("r0_no_stall", stall, 0);
    chk("r0_ex_wdst", ex_wdst, 0);
    chk("r0_ex_valid", ex_valid, 1);
    idle(1);
    chk("r0_sub_in_ex", ex_wdst, 6);
    idle(3);
    cyc(1'b1, OP_LW, 5'd0, 5'd5, 5'd0, 1'b0);
    cyc(1'b0, OP_SUB, 5'd5, 5'd1, 5'd6, 1'b0);
    chk("inv_no_stall", stall, 0);
    idle(3);

`ifdef DATA_FWD_EN
    // Two writers of r3: the younger one (in MEM) wins over WB
    cyc(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    cyc(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    cyc(1'b1, OP_ADD, 5'd3, 5'd0, 5'd4, 1'b0);
    chk("mw_nostall", stall, 0);
    idle(1);
    chk("mw_fwd_a_mem", fwd_a, 2'b01);
    chk("mw_fwd_b_none", fwd_b, 2'b00);
    idle(3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
